// File: rtl/bound_flasher_pkg.sv
// Shared types and constants for the bound_flasher LED sequencer.
package bound_flasher_pkg;

    localparam int LAMPS = 16;
    localparam int CW    = 5;

    // Level-count landmarks of the bouncing sequence.
    localparam logic [CW-1:0] KICK_LO = 5'd6;
    localparam logic [CW-1:0] KICK_HI = 5'd11;
    localparam logic [CW-1:0] MID_MIN = 5'd5;
    localparam logic [CW-1:0] MAX_C   = 5'd16;

    // Sequencer phases; encoding 3'd7 is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP_A = 3'd1,
        DN_A = 3'd2,
        UP_B = 3'd3,
        DN_B = 3'd4,
        UP_C = 3'd5,
        DN_C = 3'd6
    } state_t;

endpackage

// File: rtl/flasher_bar_dec.sv
// Thermometer decoder: lamp i is lit whenever i is below the level count.
module flasher_bar_dec
    import bound_flasher_pkg::*;
(
    input  logic [CW-1:0]    level,
    output logic [LAMPS-1:0] bar
);

    // Each lamp compares its own index against the level.
    always_comb begin
        bar = '0;
        for (int i = 0; i < LAMPS; i++) begin
            bar[i] = (CW'(i) < level);
        end
    end

endmodule

// File: rtl/bound_flasher.sv
// Bouncing LED bar sequencer: FSM plus level counter, LEDs driven from registers.
module bound_flasher
    import bound_flasher_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    output logic [LAMPS-1:0] LEDs
);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    c;
    logic [CW-1:0]    c_nxt;
    logic [LAMPS-1:0] bar_nxt;

    // Next phase and level, evaluated from the current level and flick.
    always_comb begin
        state_nxt = state;
        c_nxt     = c;
        case (state)
            IDLE: begin
                if (flick) begin
                    state_nxt = UP_A;
                    c_nxt     = 5'd1;
                end else begin
                    c_nxt = '0;
                end
            end
            UP_A: begin
                if (c >= KICK_LO) begin
                    state_nxt = DN_A;
                    c_nxt     = c - 5'd1;
                end else begin
                    c_nxt = c + 5'd1;
                    if (c == MID_MIN) begin
                        state_nxt = DN_A;
                    end
                end
            end
            DN_A: begin
                if (c == '0) begin
                    state_nxt = UP_B;
                    c_nxt     = 5'd1;
                end else begin
                    c_nxt = c - 5'd1;
                end
            end
            UP_B: begin
                if (c == KICK_LO && flick) begin
                    state_nxt = DN_A;
                    c_nxt     = MID_MIN;
                end else if (c >= KICK_HI) begin
                    state_nxt = flick ? DN_A : DN_B;
                    c_nxt     = KICK_HI - 5'd1;
                end else begin
                    c_nxt = c + 5'd1;
                end
            end
            DN_B: begin
                if (c <= MID_MIN) begin
                    state_nxt = UP_C;
                    c_nxt     = KICK_LO;
                end else begin
                    c_nxt = c - 5'd1;
                end
            end
            UP_C: begin
                if (c == KICK_HI && flick) begin
                    state_nxt = DN_B;
                    c_nxt     = KICK_HI - 5'd1;
                end else if (c >= MAX_C) begin
                    state_nxt = DN_C;
                    c_nxt     = MAX_C - 5'd1;
                end else begin
                    c_nxt = c + 5'd1;
                end
            end
            DN_C: begin
                if (c == '0) begin
                    state_nxt = IDLE;
                    c_nxt     = '0;
                end else begin
                    c_nxt = c - 5'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                c_nxt     = '0;
            end
        endcase
    end

    flasher_bar_dec u_dec (
        .level (c_nxt),
        .bar   (bar_nxt)
    );

    // Register phase, level and the decoded bar together so LEDs track c exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            c     <= '0;
            LEDs  <= '0;
        end else begin
            state <= state_nxt;
            c     <= c_nxt;
            LEDs  <= bar_nxt;
        end
    end

endmodule

// File: tb/tb_bound_flasher.sv
// Directed testbench for bound_flasher: expected level sequences built from ranges.
module tb_bound_flasher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flick;
    logic [15:0] LEDs;

    int total = 0;
    int bad   = 0;

    int exp_c[$];
    bit exp_f[$];

    always #5 clk = ~clk;

    bound_flasher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flick (flick),
        .LEDs  (LEDs)
    );

    // Expected bar for a level count, as (2^c)-1.
    function automatic logic [15:0] bar_of(input int c);
        logic [31:0] w;
        w = (32'd1 << c) - 32'd1;
        return w[15:0];
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive flick for one clock and return at the following falling edge.
    task automatic applyStimulus(input bit f);
        flick = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Queue levels a..b (either direction), each produced by a step with flick=f.
    task automatic push_range(input int a, input int b, input bit f);
        if (a <= b) begin
            for (int v = a; v <= b; v++) begin
                exp_c.push_back(v);
                exp_f.push_back(f);
            end
        end else begin
            for (int v = a; v >= b; v--) begin
                exp_c.push_back(v);
                exp_f.push_back(f);
            end
        end
    endtask

    task automatic run_vectors(input string name);
        for (int i = 0; i < exp_c.size(); i++) begin
            applyStimulus(exp_f[i]);
            checkOutput($sformatf("%s[%0d]", name, i), LEDs, bar_of(exp_c[i]));
        end
        exp_c.delete();
        exp_f.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        flick = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset", LEDs, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("idle[%0d]", i), LEDs, 16'h0000);
        end

        // Nominal run, flick high for two cycles from IDLE.
        push_range(1, 2, 1'b1);
        push_range(3, 6, 1'b0);
        push_range(5, 0, 1'b0);
        push_range(1, 11, 1'b0);
        push_range(10, 5, 1'b0);
        push_range(6, 16, 1'b0);
        push_range(15, 0, 1'b0);
        repeat (3) push_range(0, 0, 1'b0);
        run_vectors("nominal");

        // Kickback at LED5 during UP_B.
        push_range(1, 1, 1'b1);
        push_range(2, 6, 1'b0);
        push_range(5, 0, 1'b0);
        push_range(1, 6, 1'b0);
        push_range(5, 5, 1'b1);
        push_range(4, 0, 1'b0);
        push_range(1, 11, 1'b0);
        push_range(10, 5, 1'b0);
        push_range(6, 16, 1'b0);
        push_range(15, 0, 1'b0);
        repeat (2) push_range(0, 0, 1'b0);
        run_vectors("kick5");

        // Kickback at LED10 during UP_C.
        push_range(1, 1, 1'b1);
        push_range(2, 6, 1'b0);
        push_range(5, 0, 1'b0);
        push_range(1, 11, 1'b0);
        push_range(10, 5, 1'b0);
        push_range(6, 11, 1'b0);
        push_range(10, 10, 1'b1);
        push_range(9, 5, 1'b0);
        push_range(6, 16, 1'b0);
        push_range(15, 0, 1'b0);
        repeat (2) push_range(0, 0, 1'b0);
        run_vectors("kick10");

        // flick ignored in UP_A, DN_A and at full bar; held flick after DN_C
        // still gives one dark IDLE cycle before restarting.
        push_range(1, 6, 1'b1);
        push_range(5, 0, 1'b1);
        push_range(1, 1, 1'b1);
        push_range(2, 11, 1'b0);
        push_range(10, 5, 1'b0);
        push_range(6, 16, 1'b0);
        push_range(15, 15, 1'b1);
        push_range(14, 0, 1'b0);
        push_range(0, 0, 1'b1);
        push_range(1, 1, 1'b1);
        push_range(2, 6, 1'b0);
        push_range(5, 0, 1'b0);
        push_range(1, 9, 1'b0);
        run_vectors("ignored");

        // Asynchronous reset between edges while LEDs=01FF.
        checkOutput("pre_rst", LEDs, 16'h01FF);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst", LEDs, 16'h0000);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("post_rst[%0d]", i), LEDs, 16'h0000);
        end
        push_range(1, 1, 1'b1);
        push_range(2, 3, 1'b0);
        run_vectors("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
